// File: rtl/rom_loader_pkg.sv
// Shared types for the boot loader: FSM state encoding, ROM word type and
// the helper that zero-fills the unused low bytes of a partial final word.
package cpu_pkg;

    typedef enum logic [1:0] {LOAD, PAD, RELEASE, RUN} loader_state_t;

    typedef logic [31:0] word_t;

    localparam int BYTES_PER_WORD = 4;

    // n = bytes already received (1..3); they sit right-justified in acc
    function automatic word_t pad_word(input word_t acc, input logic [1:0] n);
        word_t w;
        case (n)
            2'd1:    w = {acc[7:0],  24'h0};
            2'd2:    w = {acc[15:0], 16'h0};
            2'd3:    w = {acc[23:0], 8'h0};
            default: w = acc;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream load port, core fetch port and loader status bundled together.
interface rom_loader_if #(parameter int IP_W = 16) ();
    import cpu_pkg::*;

    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_last;
    logic            in_ready;
    logic [IP_W-1:0] ip;
    word_t           instr;
    logic            instr_valid;
    logic            ip_fault;
    logic            overflow;
    logic [IP_W-1:0] word_count;
    logic            core_rstn;

    modport slave (
        input  in_valid, in_data, in_last, ip,
        output in_ready, instr, instr_valid, ip_fault, overflow, word_count, core_rstn
    );

    modport master (
        output in_valid, in_data, in_last, ip,
        input  in_ready, instr, instr_valid, ip_fault, overflow, word_count, core_rstn
    );

endinterface

// File: rtl/rom_loader_rom_sp.sv
// Instruction store: one synchronous write port, one registered read port.
// A read of the address being written returns the previous contents.
module rom_sp
    import cpu_pkg::*;
#(
    parameter int  DEPTH = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  word_t         i_wdata,
    input  logic [AW-1:0] i_raddr,
    output word_t         o_rdata
);

    word_t r_mem [DEPTH];
    word_t r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // storage itself is deliberately left untouched by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) r_rdata <= '0;
        else       r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rom_loader.sv
// Boot loader: packs a big-endian byte stream into ROM words, holds the core
// in reset for a fixed delay after loading, then serves bounds-checked fetches.
//
//   state   | meaning
//   LOAD    | accepting image bytes, writing each completed word
//   PAD     | zero-filling and writing a partial final word (one cycle)
//   RELEASE | image complete, counting down before core reset release
//   RUN     | core out of reset, fetches checked against word_count
module rom_loader
    import cpu_pkg::*;
#(
    parameter int ROM_SIZE      = 512,
    parameter int IP_W          = 16,
    parameter int RELEASE_DELAY = 2
) (
    input logic         i_clk,
    input logic         i_rst,
    rom_loader_if.slave bus
);

    localparam int              AW       = $clog2(ROM_SIZE);
    localparam logic [IP_W-1:0] FULL     = IP_W'(ROM_SIZE);
    localparam logic [IP_W-1:0] DLY_INIT = IP_W'(RELEASE_DELAY - 1);

    loader_state_t   r_state, w_next;
    word_t           r_asm;
    logic [1:0]      r_lane;
    logic [IP_W-1:0] r_wr_addr;
    logic [IP_W-1:0] r_dly;
    logic            r_overflow;
    logic            r_fault;
    logic            r_instr_valid;
    logic            r_core_rstn;

    logic            w_xfer;
    logic            w_full;
    logic            w_we;
    word_t           w_shift;
    word_t           w_wdata;

    assign bus.in_ready = (r_state == LOAD) && !i_rst;
    assign w_xfer       = bus.in_valid && bus.in_ready;
    assign w_full       = (r_wr_addr == FULL);
    assign w_shift      = {r_asm[23:0], bus.in_data};

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= LOAD;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_wdata = w_shift;
        case (r_state)
            LOAD: begin
                if (w_xfer) begin
                    if (!w_full && r_lane == 2'd3) w_we = 1'b1;
                    if (bus.in_last) w_next = (w_full || r_lane == 2'd3) ? RELEASE : PAD;
                end
            end
            PAD: begin
                w_we    = 1'b1;
                w_wdata = pad_word(r_asm, r_lane);
                w_next  = RELEASE;
            end
            RELEASE: begin
                if (r_dly == '0) w_next = RUN;
            end
            default: ;
        endcase
    end

    // r_lane counts bytes held in r_asm; in PAD it is the partial-word length
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_asm      <= '0;
            r_lane     <= '0;
            r_wr_addr  <= '0;
            r_dly      <= DLY_INIT;
            r_overflow <= 1'b0;
        end else begin
            if (w_xfer) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else if (r_lane == 2'd3) begin
                    r_asm  <= '0;
                    r_lane <= '0;
                end else begin
                    r_asm  <= w_shift;
                    r_lane <= r_lane + 2'd1;
                end
            end
            if (w_we)               r_wr_addr <= r_wr_addr + 1'b1;
            if (r_state == RELEASE) r_dly     <= r_dly - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_core_rstn   <= 1'b0;
        end else begin
            r_instr_valid <= (r_state == RUN) && (bus.ip < r_wr_addr);
            r_fault       <= r_fault || ((r_state == RUN) && (bus.ip >= r_wr_addr));
            r_core_rstn   <= (r_state == RUN);
        end
    end

    rom_sp #(.DEPTH(ROM_SIZE)) u_rom (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_we),
        .i_waddr (r_wr_addr[AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (bus.ip[AW-1:0]),
        .o_rdata (bus.instr)
    );

    assign bus.instr_valid = r_instr_valid;
    assign bus.ip_fault    = r_fault;
    assign bus.overflow    = r_overflow;
    assign bus.word_count  = r_wr_addr;
    assign bus.core_rstn   = r_core_rstn;

endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time program loader and instruction store directly upstream of the CPU `Driver`. It accepts the program image as a byte stream with a valid/ready handshake, reassembles big-endian 32-bit words into an internal ROM, then releases the core from reset. It serves single-cycle-latency instruction fetches at `ip` and flags out-of-image fetches, so test harnesses need no host-side byte swapping or bounds checks.

## Interface
- `ROM_SIZE`, 512: ROM depth in 32-bit words; must be a power of two.
- `IP_W`, 16: width of `ip` and the word counters.
- `RELEASE_DELAY`, 2: cycles between load completion and `core_rstn` going high.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  a byte is offered on `in_data`.
- `in_data`  in  8  image byte, file order.
- `in_last`  in  1  qualifies the current byte as the final byte of the image.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `ip`  in  IP_W  fetch word address from the core.
- `instr`  out  32  ROM word at the `ip` sampled in the previous cycle.
- `instr_valid`  out  1  `instr` is a legal in-image word.
- `ip_fault`  out  1  sticky; the core fetched at or beyond `word_count`.
- `overflow`  out  1  sticky; the image exceeded `ROM_SIZE*4` bytes.
- `word_count`  out  IP_W  number of words loaded, including a padded partial word.
- `core_rstn`  out  1  active-low reset to the core.

## Operation
- A byte transfers on a cycle where `in_valid` and `in_ready` are both high.
- State machine has four states: LOAD, PAD, RELEASE, RUN. Reset enters LOAD.
- LOAD:
  - `in_ready`=1.
  - Accepted bytes shift into a 32-bit assembly register, first byte into bits 31:24.
  - A byte-lane counter (0..3) tracks position in the word.
  - On lane 3, the word is written to `rom[wr_addr]`; `wr_addr` increments and the lane counter wraps to 0.
- Byte accepted with `in_last`=1:
  - If it completes a word (lane 3), write it and go to RELEASE.
  - Otherwise go to PAD.
- PAD:
  - Remaining low bytes are filled with 8'h00 and the word is written.
  - One cycle, then RELEASE. `in_ready`=0.
- Overflow:
  - When `wr_addr` = ROM_SIZE, further accepted bytes are discarded and `overflow` is set.
  - `in_ready` stays 1 until `in_last`, so the source drains.
  - `word_count` saturates at ROM_SIZE.
- `in_last` on the first byte of an image is legal and yields `word_count`=1.
- RELEASE:
  - Counts RELEASE_DELAY cycles with `core_rstn`=0, then enters RUN.
  - `in_ready`=0.
- RUN:
  - `core_rstn`=1 and `in_ready`=0. Bytes offered in RUN are ignored.
- Fetch path (all states):
  - `instr` is registered from `rom[ip[log2(ROM_SIZE)-1:0]]`.
  - `instr_valid` is registered as (state==RUN && ip < word_count).
- Fault: in RUN, `ip >= word_count` sets `ip_fault` on the next edge. It stays set until `rst`.
- ROM contents are not cleared by `rst`. Words beyond `word_count` are never reported valid.

## Timing
- Reset values:
  - state=LOAD; `in_ready`=0 in the reset cycle, then 1 from the first cycle after `rst` falls.
  - `instr`=0, `instr_valid`=0, `ip_fault`=0, `overflow`=0, `word_count`=0, `core_rstn`=0.
- Throughput: one byte per cycle in LOAD. A word write occurs in the same edge as its 4th byte.
- `word_count` updates on the edge that writes the word.
- Load completes on the last write edge. `core_rstn` rises exactly RELEASE_DELAY+1 edges after the `in_last` transfer edge when the image is word-aligned, and one edge later when padding is needed.
- Fetch latency is 1 cycle: `ip` at edge n gives `instr`/`instr_valid` after edge n.
- A fetch of the word being written in the same cycle returns the old contents; no write-through is required.
- `rst` asserted mid-load or mid-run:
  - State returns to LOAD and counters clear.
  - `core_rstn` drops to 0 on the same edge.

## Structure
- Package `cpu_pkg`:
  - `loader_state_t` enum {LOAD, PAD, RELEASE, RUN}.
  - `word_t` = logic [31:0].
  - Constant `BYTES_PER_WORD`=4.
- Sub-module `rom_sp`: single-port-write / single-port-read synchronous RAM, parameterised by depth. It holds the storage; `rom_loader` holds the FSM, assembly register and counters.

## Test plan
- Bytes 12 34 56 78 AB CD EF 01, `in_last` on the 8th byte -> rom[0]=32'h12345678, rom[1]=32'hABCDEF01, `word_count`=2, `core_rstn` rises 3 edges after the last transfer.
- 6 bytes 11 22 33 44 55 66 with `in_last` -> rom[1]=32'h55660000, `word_count`=2, PAD visited once.
- Run after a 2-word load, `ip`=1 then `ip`=2 -> `instr`=rom[1] with `instr_valid`=1, then `instr_valid`=0 and `ip_fault`=1 and sticky.
- `in_valid` toggled every other cycle -> same ROM contents as the back-to-back case; no byte lost or duplicated.
- ROM_SIZE=4 with a 20-byte image -> `overflow`=1, `word_count`=4, rom[3] holds bytes 12–15, `in_ready` high until `in_last`.
- `rst` pulsed after 5 bytes, then a fresh 4-byte image DE AD BE EF -> rom[0]=32'hDEADBEEF, `word_count`=1, no residue from the aborted load.
